// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and constants for the PISO serializer
package piso_pkg;

  // Default parallel word width.
  localparam int PISO_DEFAULT_WIDTH = 8;

  // IDLE: nothing on sout. SHIFT: a word is being emitted bit by bit.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

endpackage

// File: rtl/bit_counter.sv
// rtl/bit_counter.sv - bit position counter with clear, increment and terminal count
//   clk      rising-edge clock
//   clear_n  asynchronous active-low reset, counter to 0
//   clr      synchronous load-to-zero (wins over inc)
//   inc      synchronous increment
//   count    current bit position, 0..MODULUS-1
//   tc       high while count == MODULUS-1
module bit_counter #(
  parameter int MODULUS = 8,
  parameter int CW      = $clog2(MODULUS)
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          tc
);

  localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out word serializer with framing flags
//   clk      rising-edge clock
//   clear_n  asynchronous active-low reset
//   d        parallel word to transmit
//   d_valid  d holds a word to send
//   d_ready  word on d is accepted this cycle
//   sout     serial data bit
//   sframe   first bit of a word
//   slast    last bit of a word
//   sbusy    a word bit is on sout
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic             d_ready,
  output logic             sout,
  output logic             sframe,
  output logic             slast,
  output logic             sbusy
);

  localparam int CW = $clog2(WIDTH);

  piso_state_e      state;
  logic [WIDTH-1:0] sreg;
  logic             ready_en;
  logic [CW-1:0]    count;
  logic             tc;
  logic             in_shift;
  logic             accept;
  logic             cnt_clr;
  logic             cnt_inc;

  assign in_shift = (state == SHIFT);

  // ready_en holds d_ready low through reset and releases it on the first
  // edge after clear_n deasserts, so nothing is taken before that edge.
  // In SHIFT a new word may only land on the last bit, giving gapless streaming.
  assign d_ready = ready_en & (~in_shift | tc);
  assign accept  = d_valid & d_ready;

  // Counter restarts at every new word and also parks at 0 when the word ends idle.
  assign cnt_clr = accept | (in_shift & tc);
  assign cnt_inc = in_shift & ~tc;

  bit_counter #(
    .MODULUS (WIDTH)
  ) u_bit_counter (
    .clk     (clk),
    .clear_n (clear_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .count   (count),
    .tc      (tc)
  );

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state    <= IDLE;
      sreg     <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        state <= SHIFT;
        sreg  <= d;
      end else if (in_shift) begin
        if (tc) begin
          state <= IDLE;
        end
        // Zeros are shifted in, so the register is empty once a word is out.
        if (MSB_FIRST) begin
          sreg <= {sreg[WIDTH-2:0], 1'b0};
        end else begin
          sreg <= {1'b0, sreg[WIDTH-1:1]};
        end
      end
    end
  end

  // Outputs are gated by state so they drop the moment reset clears it.
  assign sout   = in_shift & (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
  assign sframe = in_shift & (count == '0);
  assign slast  = in_shift & tc;
  assign sbusy  = in_shift;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clear_n = 1'b0;
  logic [W-1:0] d = '0;
  logic         d_valid = 1'b0;

  logic d_ready, sout, sframe, slast, sbusy;
  logic l_ready, l_sout, l_sframe, l_slast, l_sbusy;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .clear_n(clear_n), .d(d), .d_valid(d_valid), .d_ready(d_ready),
    .sout(sout), .sframe(sframe), .slast(slast), .sbusy(sbusy)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .clear_n(clear_n), .d(d), .d_valid(d_valid), .d_ready(l_ready),
    .sout(l_sout), .sframe(l_sframe), .slast(l_slast), .sbusy(l_sbusy)
  );

  // Reference model: a queue of bit slots still to appear on the line, one per cycle.
  typedef struct {
    bit msb;
    bit lsb;
    bit first;
    bit last;
  } slot_t;

  slot_t q[$];
  bit    en = 1'b0;
  int    vectors = 0;
  int    miscompares = 0;

  logic obs_sout, obs_lsout, obs_ready, obs_busy, obs_frame, obs_last;

  task automatic push_word(input logic [W-1:0] w);
    slot_t s;
    for (int i = 0; i < W; i++) begin
      s.msb   = w[W-1-i];
      s.lsb   = w[i];
      s.first = (i == 0);
      s.last  = (i == W-1);
      q.push_back(s);
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    bit e_busy, e_sout, e_lsout, e_frame, e_last, e_ready;
    @(negedge clk);
    e_busy  = (q.size() > 0);
    e_sout  = e_busy ? q[0].msb : 1'b0;
    e_lsout = e_busy ? q[0].lsb : 1'b0;
    e_frame = e_busy ? q[0].first : 1'b0;
    e_last  = e_busy ? q[0].last : 1'b0;
    e_ready = en && clear_n && (q.size() <= 1);
    obs_sout = sout; obs_lsout = l_sout; obs_ready = d_ready;
    obs_busy = sbusy; obs_frame = sframe; obs_last = slast;
    vectors++; if (sout !== e_sout) begin miscompares++; $display("FAIL sout t=%0t got %b want %b", $time, sout, e_sout); end
    vectors++; if (l_sout !== e_lsout) begin miscompares++; $display("FAIL lsb_sout t=%0t got %b want %b", $time, l_sout, e_lsout); end
    vectors++; if (sbusy !== e_busy || l_sbusy !== e_busy) begin miscompares++; $display("FAIL sbusy t=%0t got %b/%b want %b", $time, sbusy, l_sbusy, e_busy); end
    vectors++; if (sframe !== e_frame || l_sframe !== e_frame) begin miscompares++; $display("FAIL sframe t=%0t got %b/%b want %b", $time, sframe, l_sframe, e_frame); end
    vectors++; if (slast !== e_last || l_slast !== e_last) begin miscompares++; $display("FAIL slast t=%0t got %b/%b want %b", $time, slast, l_slast, e_last); end
    vectors++; if (d_ready !== e_ready || l_ready !== e_ready) begin miscompares++; $display("FAIL d_ready t=%0t got %b/%b want %b", $time, d_ready, l_ready, e_ready); end
    @(posedge clk);
    if (!clear_n) begin
      q.delete();
      en = 1'b0;
    end else begin
      if (q.size() > 0) q.delete(0);
      if (d_valid && e_ready) push_word(d);
      en = 1'b1;
    end
    #1;
  endtask

  task automatic idle_cycles(input int n);
    d_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_reset();
    logic r0, r1;
    clear_n = 1'b0; d = 8'h5A; d_valid = 1'b1;
    #1;
    vectors++;
    if ({sout, sframe, slast, sbusy, d_ready} !== 5'b0) begin
      miscompares++; $display("FAIL reset_outputs got %b want 00000", {sout, sframe, slast, sbusy, d_ready});
    end
    for (int i = 0; i < 3; i++) cycle();
    clear_n = 1'b1;
    cycle(); r0 = obs_ready;
    cycle(); r1 = obs_ready;
    vectors++;
    if ({r0, r1} !== 2'b01) begin
      miscompares++; $display("FAIL ready_after_release got %b want 01", {r0, r1});
    end
    idle_cycles(W + 1);
  endtask

  task automatic test_single_word();
    logic [W-1:0] got, fr, la;
    d = 8'hA5; d_valid = 1'b1;
    cycle();
    d_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      cycle();
      got[W-1-i] = obs_sout; fr[i] = obs_frame; la[i] = obs_last;
    end
    vectors++; if (got !== 8'hA5) begin miscompares++; $display("FAIL single_word got %h want a5", got); end
    vectors++; if (fr !== 8'h01) begin miscompares++; $display("FAIL single_frame got %b want 00000001", fr); end
    vectors++; if (la !== 8'h80) begin miscompares++; $display("FAIL single_last got %b want 10000000", la); end
    cycle();
    vectors++;
    if (obs_busy !== 1'b0 || obs_sout !== 1'b0) begin
      miscompares++; $display("FAIL single_idle got busy=%b sout=%b want 0 0", obs_busy, obs_sout);
    end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] got;
    d = 8'h01; d_valid = 1'b1;
    cycle();
    d_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      cycle();
      got[i] = obs_lsout;
    end
    vectors++; if (got !== 8'h01) begin miscompares++; $display("FAIL lsb_first got %h want 01", got); end
    idle_cycles(2);
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits, busy, rdy;
    d = 8'hFF; d_valid = 1'b1;
    cycle();
    d = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) d_valid = 1'b0;
      cycle();
      bits[15-i] = obs_sout; busy[i] = obs_busy; rdy[i] = obs_ready;
    end
    vectors++; if (bits !== 16'hFF00) begin miscompares++; $display("FAIL b2b_bits got %h want ff00", bits); end
    vectors++; if (busy !== 16'hFFFF) begin miscompares++; $display("FAIL b2b_busy got %h want ffff", busy); end
    vectors++; if (rdy[14:0] !== 15'h0080) begin miscompares++; $display("FAIL b2b_ready got %h want 0080", rdy[14:0]); end
    idle_cycles(2);
  endtask

  task automatic test_ignored_input();
    logic [W-1:0] got, rdy;
    d = 8'hA5; d_valid = 1'b1;
    cycle();
    for (int i = 0; i < W; i++) begin
      if (i == 2) d = 8'h3C;
      if (i == W-1) d_valid = 1'b0;
      cycle();
      got[W-1-i] = obs_sout; rdy[i] = obs_ready;
    end
    vectors++; if (got !== 8'hA5) begin miscompares++; $display("FAIL ignored_word got %h want a5", got); end
    vectors++; if (rdy !== 8'h80) begin miscompares++; $display("FAIL ignored_ready got %b want 10000000", rdy); end
    idle_cycles(2);
  endtask

  task automatic test_reset_mid_word();
    logic [W-1:0] got;
    d = 8'hFF; d_valid = 1'b1;
    cycle();
    d_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    // bit 4 is on the line now; pull reset between edges
    #2 clear_n = 1'b0;
    #1;
    vectors++;
    if ({sout, sbusy, d_ready} !== 3'b000) begin
      miscompares++; $display("FAIL async_reset got sout/sbusy/d_ready=%b want 000", {sout, sbusy, d_ready});
    end
    q.delete(); en = 1'b0;
    cycle();
    clear_n = 1'b1; d = 8'h81; d_valid = 1'b1;
    cycle();
    cycle();
    d_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      cycle();
      got[W-1-i] = obs_sout;
    end
    vectors++; if (got !== 8'h81) begin miscompares++; $display("FAIL after_reset_word got %h want 81", got); end
    idle_cycles(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      d       = W'($urandom);
      d_valid = ($urandom_range(0, 3) != 0);
      cycle();
    end
    idle_cycles(W + 1);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_lsb_first();
    test_back_to_back();
    test_ignored_input();
    test_reset_mid_word();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
